mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
Parametrised synchronous modulo-N up/down counter. It is the next generation of the ripple T-flip-flop counter: a single clock domain, a loadable value, selectable direction, an optional saturate mode, and cascade outputs. It sits in test and timing logic wherever a sequence or interval count is needed. Several instances chain through terminal/enable to form wider counters.

Parameters:
WIDTH, 4, bit width of count and load_value; must be >= 1.
MODULUS, 16, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
clock  input  1  single clock; all state updates on rising edge.
clear_n  input  1  asynchronous active-low reset.
sync_clear  input  1  synchronous clear to 0; highest synchronous priority.
load  input  1  synchronous load of load_value.
load_value  input  WIDTH  value loaded when load=1.
enable  input  1  count enable; also the cascade input from the lower stage's terminal.
up_down  input  1  1 = count up, 0 = count down.
count  output  WIDTH  registered current count.
terminal  output  1  combinational; high when the next enabled step crosses a range end.
wrap  output  1  registered one-cycle pulse following a wrap or saturate-hit step.

Behaviour:
- Async reset: while clear_n=0, count=0 and wrap=0 immediately, independent of clock. Release is synchronous to the next rising edge; there is no count on the release edge unless clear_n is already high at that edge.
- Synchronous priority per rising edge, highest first:
  - sync_clear=1: count<=0, wrap<=0.
  - load=1: count<=load_value if load_value<=MODULUS-1, else count<=MODULUS-1 (clamp). wrap<=0.
  - enable=1, up_down=1:
    - if count==MODULUS-1: wrap mode gives count<=0; saturate mode holds MODULUS-1. wrap<=1 in both modes.
    - else count<=count+1, wrap<=0.
  - enable=1, up_down=0:
    - if count==0: wrap mode gives count<=MODULUS-1; saturate mode holds 0. wrap<=1 in both modes.
    - else count<=count-1, wrap<=0.
  - enable=0: count holds, wrap<=0.
- terminal = enable & ~sync_clear & ~load & (up_down ? count==MODULUS-1 : count==0).
  - Purely combinational, with zero latency.
  - A higher stage's enable is driven by this stage's terminal, so the chain steps in the same edge as the wrap.
- Latency: count reflects the action one edge after its inputs are sampled. wrap is asserted for exactly the cycle after the wrapping edge.
- A direction change mid-count takes effect on the next enabled edge with no extra step. Example: count=5, up_down flips to 0, next edge gives 4.
- Saturate mode: continued enable at the end keeps wrap high every cycle while it holds. count never changes in that case.
- All arithmetic is WIDTH-bit and unsigned; no intermediate value may exceed MODULUS-1. When MODULUS=2**WIDTH, the compare and wrap must not overflow.
- sync_clear or load asserted in the same cycle as a terminal step overrides the step. terminal=0 and wrap=0 in that case.
- If count holds an out-of-range value, the next enabled up step wraps to 0 (or saturates), and a down step decrements normally. This state is unreachable after reset.

Test Plan:
- WIDTH=4, MODULUS=10, SATURATE=0: reset, enable=1, up_down=1 for 12 cycles -> count 1..9,0,1,2; terminal high when count=9; wrap high the cycle count=0.
- Same config, down: load_value=2 loaded, then 4 enabled down steps -> count 1,0,9,8; terminal at count=0; wrap pulse after 0->9.
- SATURATE=1, MODULUS=10: count up from 7 for 5 cycles -> 8,9,9,9,9; wrap high on each cycle from the first hold onward; deasserts when enable drops.
- Priority: at count=9 with enable=1, assert load=1 with load_value=3 -> count=3, wrap=0, terminal=0. load_value=15 -> count=9 (clamp). sync_clear together with load -> count=0.
- Async reset mid-count: drive clear_n low between edges at count=6 -> count=0 and wrap=0 before the next edge; hold for 3 edges, count stays 0; release, then the first enabled edge gives 1.
- Cascade: two WIDTH=4, MODULUS=16 instances, low.terminal driving high.enable, count up from 0x0F -> next edge gives low=0, high=1; from 0xFF -> both 0, both wrap pulses high the same cycle.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter with load, optional saturation and
// cascade outputs (terminal feeds the next stage's enable, wrap flags the end step).
module mod_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             sync_clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap
);

  // MODULUS-1 always fits in WIDTH bits, so the cast never truncates.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_top, at_bottom, end_hit, step;
  logic [WIDTH-1:0] load_clamped;

  // >= also catches an out-of-range count, so an up step from there wraps or saturates.
  assign at_top       = (count_q >= MaxVal);
  assign at_bottom    = (count_q == '0);
  assign end_hit      = up_down ? at_top : at_bottom;
  assign step         = enable & ~sync_clear & ~load;
  assign terminal     = step & end_hit;
  assign load_clamped = (load_value > MaxVal) ? MaxVal : load_value;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (sync_clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (enable) begin
      if (end_hit) begin
        wrap_d = 1'b1;
        if (SATURATE) begin
          count_d = up_down ? MaxVal : '0;
        end else begin
          count_d = up_down ? '0 : MaxVal;
        end
      end else if (up_down) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: wrap and saturate mod-10 instances plus a
// two-stage mod-16 cascade.
module tb_mod_updown_counter;

  typedef struct {
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;

  logic       w_sc = 0, w_ld = 0, w_en = 0, w_ud = 1;
  logic [3:0] w_lv = '0, w_count;
  logic       w_term, w_wrap;

  logic       s_sc = 0, s_ld = 0, s_en = 0, s_ud = 1;
  logic [3:0] s_lv = '0, s_count;
  logic       s_term, s_wrap;

  logic       c_sc = 0, c_en = 0, c_ud = 1;
  logic       lo_ld = 0, hi_ld = 0;
  logic [3:0] lo_lv = '0, hi_lv = '0, lo_count, hi_count;
  logic       lo_term, lo_wrap, hi_term, hi_wrap;

  always #5 clock = ~clock;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clock(clock), .clear_n(clear_n), .sync_clear(w_sc), .load(w_ld), .load_value(w_lv),
    .enable(w_en), .up_down(w_ud), .count(w_count), .terminal(w_term), .wrap(w_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clock(clock), .clear_n(clear_n), .sync_clear(s_sc), .load(s_ld), .load_value(s_lv),
    .enable(s_en), .up_down(s_ud), .count(s_count), .terminal(s_term), .wrap(s_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_lo (
    .clock(clock), .clear_n(clear_n), .sync_clear(c_sc), .load(lo_ld), .load_value(lo_lv),
    .enable(c_en), .up_down(c_ud), .count(lo_count), .terminal(lo_term), .wrap(lo_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_hi (
    .clock(clock), .clear_n(clear_n), .sync_clear(c_sc), .load(hi_ld), .load_value(hi_lv),
    .enable(lo_term), .up_down(c_ud), .count(hi_count), .terminal(hi_term), .wrap(hi_wrap)
  );

  task automatic push_exp(input logic [15:0] v, input string t);
    exp_t e;
    e.val = v;
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic drive_w(input logic sc, input logic ld, input logic en, input logic ud,
                         input logic [3:0] lv);
    @(negedge clock);
    w_sc = sc; w_ld = ld; w_en = en; w_ud = ud; w_lv = lv;
    #1;
  endtask

  task automatic drive_s(input logic sc, input logic ld, input logic en, input logic ud,
                         input logic [3:0] lv);
    @(negedge clock);
    s_sc = sc; s_ld = ld; s_en = en; s_ud = ud; s_lv = lv;
    #1;
  endtask

  task automatic drive_c(input logic lld, input logic [3:0] llv, input logic hld,
                         input logic [3:0] hlv, input logic en);
    @(negedge clock);
    lo_ld = lld; lo_lv = llv; hi_ld = hld; hi_lv = hlv; c_en = en; c_ud = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    w_en = 1'b1;
    #1;
    checks++;
    if ({w_wrap, w_count, s_wrap, s_count, lo_count, hi_count} !== 18'h0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0",
               {w_wrap, w_count, s_wrap, s_count, lo_count, hi_count});
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({w_wrap, w_count} !== 5'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h want 0", {w_wrap, w_count});
    end
    @(negedge clock);
    w_en = 1'b0;
    clear_n = 1'b1;
  endtask

  task automatic test_count_up();
    logic [3:0] exp_cnt [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                 4'd0, 4'd1, 4'd2};
    logic [3:0] cur = 4'd0;
    exp_t       e;
    for (int i = 0; i < 12; i++) begin
      drive_w(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      checks++;
      if (w_term !== (cur == 4'd9)) begin
        errors++;
        $display("FAIL up_term[%0d]: got %b want %b", i, w_term, (cur == 4'd9));
      end
      push_exp({11'b0, (cur == 4'd9), exp_cnt[i]}, "up_step");
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if ({11'b0, w_wrap, w_count} !== e.val) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", e.tag, i, {11'b0, w_wrap, w_count}, e.val);
      end
      cur = exp_cnt[i];
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_cnt [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic [3:0] cur = 4'd2;
    exp_t       e;
    drive_w(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    push_exp(16'h0002, "down_load");
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    if ({11'b0, w_wrap, w_count} !== e.val) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, {11'b0, w_wrap, w_count}, e.val);
    end
    for (int i = 0; i < 4; i++) begin
      drive_w(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      checks++;
      if (w_term !== (cur == 4'd0)) begin
        errors++;
        $display("FAIL down_term[%0d]: got %b want %b", i, w_term, (cur == 4'd0));
      end
      push_exp({11'b0, (cur == 4'd0), exp_cnt[i]}, "down_step");
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if ({11'b0, w_wrap, w_count} !== e.val) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", e.tag, i, {11'b0, w_wrap, w_count}, e.val);
      end
      cur = exp_cnt[i];
    end
  endtask

  task automatic test_direction();
    logic [3:0] lv  [4] = '{4'd5, 4'd0, 4'd0, 4'd0};
    logic       ld  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       ud  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_cnt [4] = '{4'd5, 4'd6, 4'd5, 4'd4};
    exp_t       e;
    for (int i = 0; i < 4; i++) begin
      drive_w(1'b0, ld[i], 1'b1, ud[i], lv[i]);
      push_exp({12'b0, exp_cnt[i]}, "direction");
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if ({11'b0, w_wrap, w_count} !== e.val) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", e.tag, i, {11'b0, w_wrap, w_count}, e.val);
      end
    end
  endtask

  task automatic test_saturate();
    // load 7, five up steps, enable off, sync clear, two down steps at 0
    logic       sc  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       ld  [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic       en  [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    logic       ud  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       trm [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    logic       wrp [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    logic [3:0] cnt [10] = '{4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};
    exp_t       e;
    for (int i = 0; i < 10; i++) begin
      drive_s(sc[i], ld[i], en[i], ud[i], 4'd7);
      checks++;
      if (s_term !== trm[i]) begin
        errors++;
        $display("FAIL sat_term[%0d]: got %b want %b", i, s_term, trm[i]);
      end
      push_exp({11'b0, wrp[i], cnt[i]}, "saturate");
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if ({11'b0, s_wrap, s_count} !== e.val) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", e.tag, i, {11'b0, s_wrap, s_count}, e.val);
      end
    end
  endtask

  task automatic test_priority();
    // load 9; load 3 over a terminal step; reload 9; clamp 15 to 9; sync_clear over load
    logic       sc  [5] = '{0, 0, 0, 0, 1};
    logic       ld  [5] = '{1, 1, 1, 1, 1};
    logic       en  [5] = '{0, 1, 0, 1, 1};
    logic [3:0] lv  [5] = '{4'd9, 4'd3, 4'd9, 4'd15, 4'd5};
    logic [3:0] cnt [5] = '{4'd9, 4'd3, 4'd9, 4'd9, 4'd0};
    exp_t       e;
    for (int i = 0; i < 5; i++) begin
      drive_w(sc[i], ld[i], en[i], 1'b1, lv[i]);
      checks++;
      if (w_term !== 1'b0) begin
        errors++;
        $display("FAIL prio_term[%0d]: got %b want 0", i, w_term);
      end
      push_exp({12'b0, cnt[i]}, "priority");
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if ({11'b0, w_wrap, w_count} !== e.val) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", e.tag, i, {11'b0, w_wrap, w_count}, e.val);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive_w(1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
    push_exp(16'h0006, "areset_load");
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    if ({11'b0, w_wrap, w_count} !== e.val) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, {11'b0, w_wrap, w_count}, e.val);
    end
    drive_w(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    checks++;
    if (s_wrap !== 1'b1) begin
      errors++;
      $display("FAIL areset_sat_wrap_before: got %b want 1", s_wrap);
    end
    clear_n = 1'b0;
    #1;
    checks++;
    if ({w_wrap, w_count, s_wrap} !== 6'h0) begin
      errors++;
      $display("FAIL areset_immediate: got %h want 0", {w_wrap, w_count, s_wrap});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if ({w_wrap, w_count} !== 5'h0) begin
        errors++;
        $display("FAIL areset_hold[%0d]: got %h want 0", i, {w_wrap, w_count});
      end
    end
    @(negedge clock);
    clear_n = 1'b1;
    push_exp(16'h0001, "areset_release");
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    if ({11'b0, w_wrap, w_count} !== e.val) begin
      errors++;
      $display("FAIL %s: got %h want %h", e.tag, {11'b0, w_wrap, w_count}, e.val);
    end
    w_en = 1'b0;
    s_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    // cascade: expected packed as {hi_wrap, lo_wrap, hi, lo}
    logic       lld [6] = '{1, 0, 1, 0, 0, 0};
    logic [3:0] llv [6] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    logic       hld [6] = '{1, 0, 1, 0, 0, 0};
    logic [3:0] hlv [6] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    logic       en  [6] = '{0, 1, 0, 1, 1, 0};
    logic [1:0] trm [6] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00};
    logic [9:0] exv [6] = '{10'h00F, 10'h110, 10'h0FF, 10'h300, 10'h001, 10'h001};
    exp_t       e;
    for (int i = 0; i < 6; i++) begin
      drive_c(lld[i], llv[i], hld[i], hlv[i], en[i]);
      checks++;
      if ({hi_term, lo_term} !== trm[i]) begin
        errors++;
        $display("FAIL cascade_term[%0d]: got %b want %b", i, {hi_term, lo_term}, trm[i]);
      end
      push_exp({6'b0, exv[i]}, "cascade");
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if ({6'b0, hi_wrap, lo_wrap, hi_count, lo_count} !== e.val) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", e.tag, i,
                 {6'b0, hi_wrap, lo_wrap, hi_count, lo_count}, e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_direction();
    test_saturate();
    test_priority();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
